// File: rtl/xrek_contract_pkg.sv
// Shared types and packing helpers for the XREK contract decoder.
// Field offsets are derived from the width parameters so the top never hard-codes bit positions.
package xrek_contract_pkg;

  localparam int unsigned ACT_W     = 8;
  localparam int unsigned ERR_W     = 3;
  localparam int unsigned ERR_ACT   = 0;
  localparam int unsigned ERR_STRAT = 1;
  localparam int unsigned ERR_WF    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_TGT,
    S_PRM,
    S_COND,
    S_STRAT,
    S_CHECK,
    S_EMIT
  } state_e;

  typedef enum logic [3:0] {
    F_WF,
    F_STEP,
    F_ACT,
    F_TGT,
    F_PRM,
    F_PRE,
    F_EXP,
    F_FB,
    F_RB
  } field_e;

  // LSB of a field in the LSB-first packed contract; each field adds the widths of all before it.
  function automatic int unsigned field_lsb(
    input field_e      f,
    input int unsigned id_w,
    input int unsigned tgt_w,
    input int unsigned param_w,
    input int unsigned cond_w,
    input int unsigned strat_w
  );
    int unsigned off;
    off = 0;
    if (f > F_WF)   off += id_w;
    if (f > F_STEP) off += id_w;
    if (f > F_ACT)  off += ACT_W;
    if (f > F_TGT)  off += tgt_w;
    if (f > F_PRM)  off += param_w;
    if (f > F_PRE)  off += cond_w;
    if (f > F_EXP)  off += cond_w;
    if (f > F_FB)   off += strat_w;
    return off;
  endfunction

endpackage

// File: rtl/xrek_contract_fifo.sv
// Synchronous show-ahead FIFO holding packed contracts; rdata always presents the head entry.
module xrek_contract_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/xrek_contract_decoder.sv
// Queued XREK action-contract decoder: buffers packed contracts, decodes them over a fixed
// eight-state sequence, validates them and presents the fields plus an error code.
module xrek_contract_decoder
  import xrek_contract_pkg::*;
#(
  parameter int unsigned ID_W      = 32,
  parameter int unsigned TGT_W     = 256,
  parameter int unsigned PARAM_W   = 1024,
  parameter int unsigned COND_W    = 256,
  parameter int unsigned STRAT_W   = 8,
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned NUM_ACT   = 16,
  parameter int unsigned MAX_STRAT = 7
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       in_valid,
  output logic                                                       in_ready,
  input  logic [2*ID_W+ACT_W+TGT_W+PARAM_W+2*COND_W+2*STRAT_W-1:0]   in_contract,
  output logic                                                       out_valid,
  input  logic                                                       out_ready,
  output logic [ID_W-1:0]                                            out_wf_id,
  output logic [ID_W-1:0]                                            out_step_id,
  output logic [ACT_W-1:0]                                           out_act,
  output logic [TGT_W-1:0]                                           out_target,
  output logic [PARAM_W-1:0]                                         out_params,
  output logic [COND_W-1:0]                                          out_pre,
  output logic [COND_W-1:0]                                          out_expect,
  output logic [STRAT_W-1:0]                                         out_fallback,
  output logic [STRAT_W-1:0]                                         out_rollback,
  output logic [ERR_W-1:0]                                           out_err,
  output logic [$clog2(QDEPTH):0]                                    q_level,
  output logic [31:0]                                                parsed_cnt,
  output logic [15:0]                                                err_cnt
);

  localparam int unsigned CW = 2*ID_W + ACT_W + TGT_W + PARAM_W + 2*COND_W + 2*STRAT_W;

  localparam int unsigned OFF_WF   = field_lsb(F_WF,   ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);
  localparam int unsigned OFF_STEP = field_lsb(F_STEP, ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);
  localparam int unsigned OFF_ACT  = field_lsb(F_ACT,  ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);
  localparam int unsigned OFF_TGT  = field_lsb(F_TGT,  ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);
  localparam int unsigned OFF_PRM  = field_lsb(F_PRM,  ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);
  localparam int unsigned OFF_PRE  = field_lsb(F_PRE,  ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);
  localparam int unsigned OFF_EXP  = field_lsb(F_EXP,  ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);
  localparam int unsigned OFF_FB   = field_lsb(F_FB,   ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);
  localparam int unsigned OFF_RB   = field_lsb(F_RB,   ID_W, TGT_W, PARAM_W, COND_W, STRAT_W);

  state_e               state_q,    state_d;
  logic                 rdy_en_q,   rdy_en_d;
  logic [CW-1:0]        cur_q,      cur_d;
  logic                 out_valid_q, out_valid_d;
  logic [ID_W-1:0]      wf_q,       wf_d;
  logic [ID_W-1:0]      step_q,     step_d;
  logic [ACT_W-1:0]     act_q,      act_d;
  logic [TGT_W-1:0]     tgt_q,      tgt_d;
  logic [PARAM_W-1:0]   prm_q,      prm_d;
  logic [COND_W-1:0]    pre_q,      pre_d;
  logic [COND_W-1:0]    exp_q,      exp_d;
  logic [STRAT_W-1:0]   fb_q,       fb_d;
  logic [STRAT_W-1:0]   rb_q,       rb_d;
  logic [ERR_W-1:0]     err_q,      err_d;
  logic [31:0]          parsed_q,   parsed_d;
  logic [15:0]          err_cnt_q,  err_cnt_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_rdata;

  // in_ready is held low through reset and the first edge after it via rdy_en_q.
  assign in_ready  = rdy_en_q && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  xrek_contract_fifo #(
    .W     (CW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_contract),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (q_level)
  );

  always_comb begin
    state_d     = state_q;
    rdy_en_d    = 1'b1;
    cur_d       = cur_q;
    out_valid_d = out_valid_q;
    wf_d        = wf_q;
    step_d      = step_q;
    act_d       = act_q;
    tgt_d       = tgt_q;
    prm_d       = prm_q;
    pre_d       = pre_q;
    exp_d       = exp_q;
    fb_d        = fb_q;
    rb_d        = rb_q;
    err_d       = err_q;
    parsed_d    = parsed_q;
    err_cnt_d   = err_cnt_q;
    fifo_pop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_rdata;
          state_d  = S_HDR;
        end
      end
      S_HDR: begin
        wf_d    = cur_q[OFF_WF   +: ID_W];
        step_d  = cur_q[OFF_STEP +: ID_W];
        act_d   = cur_q[OFF_ACT  +: ACT_W];
        state_d = S_TGT;
      end
      S_TGT: begin
        tgt_d   = cur_q[OFF_TGT +: TGT_W];
        state_d = S_PRM;
      end
      S_PRM: begin
        prm_d   = cur_q[OFF_PRM +: PARAM_W];
        state_d = S_COND;
      end
      S_COND: begin
        pre_d   = cur_q[OFF_PRE +: COND_W];
        exp_d   = cur_q[OFF_EXP +: COND_W];
        state_d = S_STRAT;
      end
      S_STRAT: begin
        fb_d    = cur_q[OFF_FB +: STRAT_W];
        rb_d    = cur_q[OFF_RB +: STRAT_W];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        err_d[ERR_ACT]   = (32'(act_q) >= NUM_ACT);
        err_d[ERR_STRAT] = (32'(fb_q) > MAX_STRAT) || (32'(rb_q) > MAX_STRAT);
        err_d[ERR_WF]    = (wf_q == '0);
        out_valid_d      = 1'b1;
        state_d          = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          parsed_d    = parsed_q + 32'd1;
          if ((err_q != '0) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdy_en_q    <= 1'b0;
      cur_q       <= '0;
      out_valid_q <= 1'b0;
      wf_q        <= '0;
      step_q      <= '0;
      act_q       <= '0;
      tgt_q       <= '0;
      prm_q       <= '0;
      pre_q       <= '0;
      exp_q       <= '0;
      fb_q        <= '0;
      rb_q        <= '0;
      err_q       <= '0;
      parsed_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= rdy_en_d;
      cur_q       <= cur_d;
      out_valid_q <= out_valid_d;
      wf_q        <= wf_d;
      step_q      <= step_d;
      act_q       <= act_d;
      tgt_q       <= tgt_d;
      prm_q       <= prm_d;
      pre_q       <= pre_d;
      exp_q       <= exp_d;
      fb_q        <= fb_d;
      rb_q        <= rb_d;
      err_q       <= err_d;
      parsed_q    <= parsed_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_wf_id    = wf_q;
  assign out_step_id  = step_q;
  assign out_act      = act_q;
  assign out_target   = tgt_q;
  assign out_params   = prm_q;
  assign out_pre      = pre_q;
  assign out_expect   = exp_q;
  assign out_fallback = fb_q;
  assign out_rollback = rb_q;
  assign out_err      = err_q;
  assign parsed_cnt   = parsed_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_xrek_contract_decoder.sv
// Directed bench for xrek_contract_decoder with hand-computed expectations.
module tb_xrek_contract_decoder;

  localparam int ID_W    = 32;
  localparam int TGT_W   = 256;
  localparam int PARAM_W = 1024;
  localparam int COND_W  = 256;
  localparam int STRAT_W = 8;
  localparam int CW      = 2*ID_W + 8 + TGT_W + PARAM_W + 2*COND_W + 2*STRAT_W;

  logic                 clk, rst;
  logic                 in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]        in_contract;
  logic [ID_W-1:0]      out_wf_id, out_step_id;
  logic [7:0]           out_act;
  logic [TGT_W-1:0]     out_target;
  logic [PARAM_W-1:0]   out_params;
  logic [COND_W-1:0]    out_pre, out_expect;
  logic [STRAT_W-1:0]   out_fallback, out_rollback;
  logic [2:0]           out_err;
  logic [2:0]           q_level;
  logic [31:0]          parsed_cnt;
  logic [15:0]          err_cnt;

  int errors = 0;
  int checks = 0;

  xrek_contract_decoder #(
    .ID_W(32), .TGT_W(256), .PARAM_W(1024), .COND_W(256), .STRAT_W(8),
    .QDEPTH(4), .NUM_ACT(16), .MAX_STRAT(7)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_contract(in_contract),
    .out_valid(out_valid), .out_ready(out_ready), .out_wf_id(out_wf_id), .out_step_id(out_step_id),
    .out_act(out_act), .out_target(out_target), .out_params(out_params), .out_pre(out_pre),
    .out_expect(out_expect), .out_fallback(out_fallback), .out_rollback(out_rollback),
    .out_err(out_err), .q_level(q_level), .parsed_cnt(parsed_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wf;
    logic [31:0] step;
    logic [7:0]  act;
    logic [7:0]  fb;
    logic [7:0]  rb;
    logic [31:0] seed;
  } item_t;

  function automatic logic [TGT_W-1:0] tgt_of(input logic [31:0] s);
    return {8{s ^ 32'h1111_1111}};
  endfunction
  function automatic logic [PARAM_W-1:0] prm_of(input logic [31:0] s);
    return {32{s ^ 32'h2222_2222}};
  endfunction
  function automatic logic [COND_W-1:0] pre_of(input logic [31:0] s);
    return {8{s ^ 32'h3333_3333}};
  endfunction
  function automatic logic [COND_W-1:0] exp_of(input logic [31:0] s);
    return {8{s ^ 32'h4444_4444}};
  endfunction

  function automatic item_t mk(input logic [31:0] wf, input logic [31:0] step, input logic [7:0] act,
                               input logic [7:0] fb, input logic [7:0] rb, input logic [31:0] seed);
    item_t it;
    it.wf = wf; it.step = step; it.act = act; it.fb = fb; it.rb = rb; it.seed = seed;
    return it;
  endfunction

  function automatic logic [CW-1:0] pack(input item_t it);
    return {it.rb, it.fb, exp_of(it.seed), pre_of(it.seed), prm_of(it.seed), tgt_of(it.seed),
            it.act, it.step, it.wf};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], expv[63:0]);
    end
  endtask

  task automatic check_fields(input item_t it, input logic [2:0] e, input string tag);
    chk({tag, "_wf"},   64'(out_wf_id),    64'(it.wf));
    chk({tag, "_step"}, 64'(out_step_id),  64'(it.step));
    chk({tag, "_act"},  64'(out_act),      64'(it.act));
    chk({tag, "_fb"},   64'(out_fallback), 64'(it.fb));
    chk({tag, "_rb"},   64'(out_rollback), 64'(it.rb));
    chk({tag, "_err"},  64'(out_err),      64'(e));
    chk_wide({tag, "_tgt"}, 1024'(out_target), 1024'(tgt_of(it.seed)));
    chk_wide({tag, "_prm"}, out_params,         prm_of(it.seed));
    chk_wide({tag, "_pre"}, 1024'(out_pre),     1024'(pre_of(it.seed)));
    chk_wide({tag, "_exp"}, 1024'(out_expect),  1024'(exp_of(it.seed)));
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic push(input item_t it);
    int n;
    in_valid    = 1'b1;
    in_contract = pack(it);
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic emit_one(input item_t it, input logic [2:0] e, input string tag);
    wait_valid({tag, "_valid"});
    check_fields(it, e, tag);
    take();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  item_t c1, bp[5], rr[3], rs[3], sat[3];
  int n, got, seen;
  logic hs, held;
  logic [31:0] snap_wf;
  logic [7:0]  snap_act;
  logic [PARAM_W-1:0] snap_prm;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_contract = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),   64'd0);
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_q_level",   64'(q_level),    64'd0);
    chk("rst_parsed",    64'(parsed_cnt), 64'd0);
    chk("rst_err_cnt",   64'(err_cnt),    64'd0);
    chk("rst_wf",        64'(out_wf_id),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Single contract: out_valid appears 8 cycles after the accept cycle.
    c1 = mk(32'd1, 32'd2, 8'd3, 8'd1, 8'd2, 32'h0000_00C1);
    push(c1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_edges", 64'(n), 64'd7);
    check_fields(c1, 3'b000, "c1");
    take();
    chk("c1_valid_drop", 64'(out_valid),  64'd0);
    chk("c1_parsed",     64'(parsed_cnt), 64'd1);
    chk("c1_hold_wf",    64'(out_wf_id),  64'd1);
    chk("c1_err_cnt",    64'(err_cnt),    64'd0);

    push(mk(32'd5, 32'd7, 8'd20, 8'd1, 8'd1, 32'h0000_00E1));
    emit_one(mk(32'd5, 32'd7, 8'd20, 8'd1, 8'd1, 32'h0000_00E1), 3'b001, "e_act");
    push(mk(32'd6, 32'd8, 8'd2, 8'd9, 8'd0, 32'h0000_00E2));
    emit_one(mk(32'd6, 32'd8, 8'd2, 8'd9, 8'd0, 32'h0000_00E2), 3'b010, "e_fb");
    push(mk(32'd0, 32'd9, 8'd4, 8'd3, 8'd3, 32'h0000_00E3));
    emit_one(mk(32'd0, 32'd9, 8'd4, 8'd3, 8'd3, 32'h0000_00E3), 3'b100, "e_wf");
    chk("err_cnt_3", 64'(err_cnt),    64'd3);
    chk("parsed_4",  64'(parsed_cnt), 64'd4);

    // Boundaries: act 15 / strategy 7 legal, act 16 / strategy 8 illegal.
    push(mk(32'd7, 32'd1, 8'd15, 8'd7, 8'd7, 32'h0000_00B1));
    emit_one(mk(32'd7, 32'd1, 8'd15, 8'd7, 8'd7, 32'h0000_00B1), 3'b000, "b_ok");
    push(mk(32'd7, 32'd2, 8'd16, 8'd0, 8'd0, 32'h0000_00B2));
    emit_one(mk(32'd7, 32'd2, 8'd16, 8'd0, 8'd0, 32'h0000_00B2), 3'b001, "b_act16");
    push(mk(32'd7, 32'd3, 8'd0, 8'd0, 8'd8, 32'h0000_00B3));
    emit_one(mk(32'd7, 32'd3, 8'd0, 8'd0, 8'd8, 32'h0000_00B3), 3'b010, "b_rb8");
    push(mk(32'd0, 32'd4, 8'd255, 8'd200, 8'd0, 32'h0000_00B4));
    emit_one(mk(32'd0, 32'd4, 8'd255, 8'd200, 8'd0, 32'h0000_00B4), 3'b111, "b_all");
    chk("err_cnt_6", 64'(err_cnt),    64'd6);
    chk("parsed_8",  64'(parsed_cnt), 64'd8);

    // Five back-to-back with the consumer stalled: 4 queued + 1 waiting in EMIT.
    for (int i = 0; i < 5; i++) bp[i] = mk(32'(10 + i), 32'(100 + i), 8'(i), 8'd1, 8'd2, 32'(32'hBB00 + i));
    for (int i = 0; i < 5; i++) push(bp[i]);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_level_full",   64'(q_level),  64'd4);
    repeat (12) @(posedge clk);
    #1;
    chk("bp_emit_held",    64'(out_valid),  64'd1);
    chk("bp_level_still",  64'(q_level),    64'd4);
    chk("bp_ready_still",  64'(in_ready),   64'd0);
    chk("bp_parsed_still", 64'(parsed_cnt), 64'd8);
    for (int i = 0; i < 5; i++) emit_one(bp[i], 3'b000, "bp");
    chk("bp_parsed",  64'(parsed_cnt), 64'd13);
    chk("bp_drained", 64'(q_level),    64'd0);

    // Random out_ready: held outputs stay stable, each contract consumed once in order.
    for (int i = 0; i < 3; i++) rr[i] = mk(32'(30 + i), 32'(300 + i), 8'(5 + i), 8'd0, 8'd3, 32'(32'hCC00 + i));
    for (int i = 0; i < 3; i++) push(rr[i]);
    got = 0;
    for (int cyc = 0; cyc < 400 && got < 3; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      hs        = out_valid && out_ready;
      held      = out_valid && !out_ready;
      snap_wf   = out_wf_id;
      snap_act  = out_act;
      snap_prm  = out_params;
      if (hs) check_fields(rr[got], 3'b000, "rnd");
      @(posedge clk); #1;
      if (hs) got++;
      if (held) begin
        chk("rnd_hold_valid", 64'(out_valid), 64'd1);
        chk("rnd_hold_wf",    64'(out_wf_id), 64'(snap_wf));
        chk("rnd_hold_act",   64'(out_act),   64'(snap_act));
        chk_wide("rnd_hold_prm", out_params,  snap_prm);
      end
    end
    out_ready = 1'b0;
    chk("rnd_all_seen", 64'(got),        64'd3);
    chk("rnd_parsed",   64'(parsed_cnt), 64'd16);
    repeat (10) @(posedge clk);
    #1;
    chk("rnd_no_extra", 64'(out_valid), 64'd0);

    // Reset while the first of three contracts is in PRM and two sit in the queue.
    for (int i = 0; i < 3; i++) rs[i] = mk(32'(50 + i), 32'd5, 8'd1, 8'd1, 8'd1, 32'(32'hDD00 + i));
    for (int i = 0; i < 3; i++) push(rs[i]);
    @(posedge clk); #1;
    chk("mid_level_2", 64'(q_level), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",  64'(out_valid),  64'd0);
    chk("mid_rst_level",  64'(q_level),    64'd0);
    chk("mid_rst_ready",  64'(in_ready),   64'd0);
    chk("mid_rst_parsed", 64'(parsed_cnt), 64'd0);
    chk("mid_rst_errcnt", 64'(err_cnt),    64'd0);
    chk("mid_rst_wf",     64'(out_wf_id),  64'd0);
    chk_wide("mid_rst_prm", out_params, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("mid_no_emit",   64'(seen),       64'd0);
    chk("mid_parsed_0",  64'(parsed_cnt), 64'd0);
    chk("mid_level_0",   64'(q_level),    64'd0);

    // Error counter saturation starting from 16'hFFFE.
    force dut.err_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.err_cnt_q;
    @(posedge clk); #1;
    chk("sat_preset", 64'(err_cnt), 64'hFFFE);
    sat[0] = mk(32'd60, 32'd1, 8'd200, 8'd0, 8'd0, 32'h0000_00F0);
    sat[1] = mk(32'd0,  32'd2, 8'd1,   8'd0, 8'd0, 32'h0000_00F1);
    sat[2] = mk(32'd61, 32'd3, 8'd1,   8'd9, 8'd0, 32'h0000_00F2);
    push(sat[0]);
    emit_one(sat[0], 3'b001, "sat0");
    chk("sat_cnt_0", 64'(err_cnt), 64'hFFFF);
    push(sat[1]);
    emit_one(sat[1], 3'b100, "sat1");
    chk("sat_cnt_1", 64'(err_cnt), 64'hFFFF);
    push(sat[2]);
    emit_one(sat[2], 3'b010, "sat2");
    chk("sat_cnt_2",  64'(err_cnt),    64'hFFFF);
    chk("sat_parsed", 64'(parsed_cnt), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
